// File: rtl/control_multiciclo.sv
// Multi-cycle MIPS32 main control: FETCH/DECODE/EXEC/MEM/WB sequencing, 3-5 cycles per instruction.
// Holds in FETCH, MEMRD and MEMWR while mem_ready is low; illegal opcodes park in TRAP until rst.
module control_multiciclo #(
  parameter int SIZEOP      = 6,
  parameter int SIZE_ALU_OP = 2,
  parameter int SIZE_EST    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SIZEOP-1:0]      opcode,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   IRWrite,
  output logic                   ALUSrcA,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic [1:0]             PCSource,
  output logic [1:0]             ALUSrcB,
  output logic [SIZE_ALU_OP-1:0] AluOP,
  output logic [SIZE_EST-1:0]    estado,
  output logic                   fin_instr,
  output logic                   ilegal
);

  localparam logic [SIZE_EST-1:0] S_FETCH    = SIZE_EST'(0);
  localparam logic [SIZE_EST-1:0] S_DECODE   = SIZE_EST'(1);
  localparam logic [SIZE_EST-1:0] S_MEMADR   = SIZE_EST'(2);
  localparam logic [SIZE_EST-1:0] S_MEMRD    = SIZE_EST'(3);
  localparam logic [SIZE_EST-1:0] S_MEMWB    = SIZE_EST'(4);
  localparam logic [SIZE_EST-1:0] S_MEMWR    = SIZE_EST'(5);
  localparam logic [SIZE_EST-1:0] S_EXEC     = SIZE_EST'(6);
  localparam logic [SIZE_EST-1:0] S_RTYPE_WB = SIZE_EST'(7);
  localparam logic [SIZE_EST-1:0] S_BRANCH   = SIZE_EST'(8);
  localparam logic [SIZE_EST-1:0] S_JUMP     = SIZE_EST'(9);
  localparam logic [SIZE_EST-1:0] S_ADDI_EX  = SIZE_EST'(10);
  localparam logic [SIZE_EST-1:0] S_ADDI_WB  = SIZE_EST'(11);
  localparam logic [SIZE_EST-1:0] S_TRAP     = SIZE_EST'(12);

  localparam logic [SIZEOP-1:0] OP_RTYPE = SIZEOP'(6'b000000);
  localparam logic [SIZEOP-1:0] OP_LW    = SIZEOP'(6'b100011);
  localparam logic [SIZEOP-1:0] OP_SW    = SIZEOP'(6'b101011);
  localparam logic [SIZEOP-1:0] OP_BEQ   = SIZEOP'(6'b000100);
  localparam logic [SIZEOP-1:0] OP_J     = SIZEOP'(6'b000010);
  localparam logic [SIZEOP-1:0] OP_ADDI  = SIZEOP'(6'b001000);

  localparam logic [SIZE_ALU_OP-1:0] ALU_ADD   = SIZE_ALU_OP'(2'b00);
  localparam logic [SIZE_ALU_OP-1:0] ALU_SUB   = SIZE_ALU_OP'(2'b01);
  localparam logic [SIZE_ALU_OP-1:0] ALU_FUNCT = SIZE_ALU_OP'(2'b10);

  logic [SIZE_EST-1:0] state_q;
  logic [SIZE_EST-1:0] state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_TRAP;
        endcase
      end
      // opcode is held by the IR, so only lw/sw can be seen here
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_TRAP;
      end
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_RTYPE_WB;
      S_RTYPE_WB: state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB:  state_d = S_FETCH;
      default:    state_d = S_TRAP;
    endcase
  end

  // rst gates every output so nothing (not even the mem_ready-gated FETCH strobes) leaks during reset
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    AluOP       = ALU_ADD;
    fin_instr   = 1'b0;
    ilegal      = 1'b0;
    estado      = '0;
    if (!rst) begin
      estado = state_q;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:   ALUSrcB = 2'b11;
        S_MEMADR, S_ADDI_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite  = 1'b1;
          MemtoReg  = 1'b1;
          fin_instr = 1'b1;
        end
        S_MEMWR: begin
          MemWrite  = 1'b1;
          IorD      = 1'b1;
          fin_instr = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          AluOP   = ALU_FUNCT;
        end
        S_RTYPE_WB: begin
          RegWrite  = 1'b1;
          RegDst    = 1'b1;
          fin_instr = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          AluOP       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          fin_instr   = 1'b1;
        end
        S_JUMP: begin
          PCWrite   = 1'b1;
          PCSource  = 2'b10;
          fin_instr = 1'b1;
        end
        S_ADDI_WB: begin
          RegWrite  = 1'b1;
          fin_instr = 1'b1;
        end
        S_TRAP:     ilegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: per-instruction state/control traces and latency against a table-driven model.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, fin_instr, ilegal;
  logic [1:0] PCSource, ALUSrcB, AluOP;
  logic [3:0] estado;

  always #5 clk = ~clk;

  control_multiciclo dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .AluOP(AluOP), .estado(estado), .fin_instr(fin_instr), .ilegal(ilegal)
  );

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rdst;
    logic [1:0] pcs, asb, aop;
    logic fin, ile;
  } ctl_t;

  ctl_t obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, AluOP, fin_instr, ilegal};

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000;

  // Control table straight from the state descriptions
  function automatic ctl_t exp_ctl(input int st, input bit mr);
    ctl_t c = '0;
    case (st)
      0:  begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
      1:  c.asb = 2'b11;
      2, 10: begin c.asa = 1; c.asb = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; c.fin = 1; end
      5:  begin c.mwr = 1; c.iord = 1; c.fin = mr; end
      6:  begin c.asa = 1; c.aop = 2'b10; end
      7:  begin c.rw = 1; c.rdst = 1; c.fin = 1; end
      8:  begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; c.fin = 1; end
      9:  begin c.pcw = 1; c.pcs = 2'b10; c.fin = 1; end
      11: begin c.rw = 1; c.fin = 1; end
      12: c.ile = 1;
      default: ;
    endcase
    return c;
  endfunction

  // Runs one legal instruction from FETCH with wf fetch waits and wm memory waits, checking every cycle
  task automatic do_instr(input logic [5:0] op, input int wf, input int wm, input string tag);
    int path[$];
    int st_q[$];
    bit mr_q[$];
    int nw, exp_lat, lat = 0, irw_n = 0, fin_n = 0;
    bit left = 0, back = 0;
    ctl_t e;
    case (op)
      RT: begin path = '{0, 1, 6, 7};    exp_lat = 4 + wf; end
      LW: begin path = '{0, 1, 2, 3, 4}; exp_lat = 5 + wf + wm; end
      SW: begin path = '{0, 1, 2, 5};    exp_lat = 4 + wf + wm; end
      BQ: begin path = '{0, 1, 8};       exp_lat = 3 + wf; end
      JJ: begin path = '{0, 1, 9};       exp_lat = 3 + wf; end
      default: begin path = '{0, 1, 10, 11}; exp_lat = 4 + wf; end
    endcase
    foreach (path[k]) begin
      nw = (path[k] == 0) ? wf : ((path[k] == 3 || path[k] == 5) ? wm : -1);
      if (nw < 0) begin
        st_q.push_back(path[k]); mr_q.push_back(1'($urandom));
      end else begin
        repeat (nw) begin st_q.push_back(path[k]); mr_q.push_back(1'b0); end
        st_q.push_back(path[k]); mr_q.push_back(1'b1);
      end
    end
    for (int i = 0; i < st_q.size(); i++) begin
      mem_ready = mr_q[i];
      opcode    = (st_q[i] == 0) ? 6'($urandom) : op;
      @(negedge clk);
      e = exp_ctl(st_q[i], mr_q[i]);
      total++;
      if (estado !== 4'(st_q[i])) begin
        bad++;
        $display("FAIL %s estado cyc%0d: got %0d want %0d", tag, i, estado, st_q[i]);
      end
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s ctl cyc%0d st%0d: got %h want %h", tag, i, st_q[i], obs, e);
      end
      if (obs.irw) irw_n++;
      if (obs.fin) fin_n++;
      if (left && estado == 4'd0) back = 1;
      if (estado != 4'd0) left = 1;
      if (!back) lat++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    opcode    = 6'($urandom);
    @(negedge clk);
    if (left && estado == 4'd0) back = 1;
    total++;
    if (!back || lat != exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d back=%0d want %0d", tag, lat, back, exp_lat);
    end
    total++;
    if (irw_n != 1 || fin_n != 1) begin
      bad++;
      $display("FAIL %s pulses: IRWrite=%0d fin=%0d want 1/1", tag, irw_n, fin_n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    mem_ready = 1'b1;
    opcode    = 6'($urandom);
    #12;
    total++;
    if (obs !== ctl_t'(0) || estado !== 4'd0) begin
      bad++;
      $display("FAIL reset_mr1: got ctl=%h estado=%0d want 0/0", obs, estado);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (estado !== 4'd0 || obs !== exp_ctl(0, 0)) begin
      bad++;
      $display("FAIL reset_release: got ctl=%h estado=%0d want %h/0", obs, estado, exp_ctl(0, 0));
    end
  endtask

  task automatic test_rtype;
    do_instr(RT, 0, 0, "rtype");
  endtask

  task automatic test_lw_waits;
    do_instr(LW, 2, 3, "lw_wait");
  endtask

  task automatic test_back_to_back;
    do_instr(SW, 0, 0, "sw");
    do_instr(BQ, 0, 0, "beq");
    do_instr(JJ, 0, 0, "j");
    do_instr(AI, 0, 0, "addi");
  endtask

  task automatic test_random;
    logic [5:0] ops[6] = '{RT, LW, SW, BQ, JJ, AI};
    for (int n = 0; n < 16; n++)
      do_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), "rand");
  endtask

  task automatic test_trap;
    mem_ready = 1'b1;
    opcode    = 6'($urandom);
    @(posedge clk); #1;
    opcode    = 6'b111111;
    mem_ready = 1'($urandom);
    @(negedge clk);
    total++;
    if (estado !== 4'd1) begin
      bad++;
      $display("FAIL trap_decode: got %0d want 1", estado);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      opcode    = 6'($urandom);
      @(negedge clk);
      total++;
      if (estado !== 4'd12 || obs !== exp_ctl(12, 0)) begin
        bad++;
        $display("FAIL trap_hold cyc%0d: estado=%0d ctl=%h want 12/%h", i, estado, obs, exp_ctl(12, 0));
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs !== ctl_t'(0) || estado !== 4'd0) begin
      bad++;
      $display("FAIL trap_rst: got ctl=%h estado=%0d want 0/0", obs, estado);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (estado !== 4'd0 || obs !== exp_ctl(0, 0)) begin
      bad++;
      $display("FAIL trap_exit: got ctl=%h estado=%0d want %h/0", obs, estado, exp_ctl(0, 0));
    end
  endtask

  task automatic test_reset_in_memwr;
    mem_ready = 1'b1;
    opcode    = 6'($urandom);
    @(posedge clk); #1;
    opcode    = SW;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (estado !== 4'd5 || MemWrite !== 1'b1) begin
      bad++;
      $display("FAIL memwr_wait: estado=%0d MemWrite=%0d want 5/1", estado, MemWrite);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== ctl_t'(0) || estado !== 4'd0) begin
      bad++;
      $display("FAIL memwr_rst: got ctl=%h estado=%0d want 0/0", obs, estado);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== ctl_t'(0)) begin
      bad++;
      $display("FAIL memwr_rst_hold: got ctl=%h want 0", obs);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (estado !== 4'd0 || MemWrite !== 1'b0) begin
      bad++;
      $display("FAIL memwr_after: estado=%0d MemWrite=%0d want 0/0", estado, MemWrite);
    end
    do_instr(RT, 1, 0, "post_rst_rtype");
    do_instr(SW, 0, 2, "post_rst_sw");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_waits();
    test_back_to_back();
    test_random();
    test_trap();
    test_reset_in_memwr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multi-cycle main control FSM for the MIPS32 datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, including the 2-bit `AluOP` consumed by the ALU control decoder. It also stalls on a single memory-ready handshake shared by instruction and data accesses.

## Interface
- `SIZEOP`, 6, opcode width (instruction bits 31:26)
- `SIZE_ALU_OP`, 2, width of `AluOP`
- `SIZE_EST`, 4, width of state encoding
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `opcode`  in  SIZEOP  opcode from instruction register; stable from the cycle after IR load
- `mem_ready`  in  1  memory has completed the current read/write this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath controls
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `ALUSrcB`  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `AluOP`  out  SIZE_ALU_OP  00 add, 01 subtract, 10 funct-decoded
- `estado`  out  SIZE_EST  current state code
- `fin_instr`  out  1  high in the final cycle of every completed instruction
- `ilegal`  out  1  high while in TRAP

## Operation
- One clock, `clk`. Reset is asynchronous and active-high on `rst`.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Any other opcode is illegal.
- State codes and transitions:
  - 0 FETCH: to DECODE when `mem_ready`=1, else hold.
  - 1 DECODE: to MEMADR for lw/sw, EXEC for R-type, BRANCH for beq, JUMP for j, ADDI_EX for addi, TRAP for anything else.
  - 2 MEMADR: to MEMRD for lw, MEMWR for sw.
  - 3 MEMRD: to MEMWB when `mem_ready`=1, else hold.
  - 4 MEMWB: to FETCH.
  - 5 MEMWR: to FETCH when `mem_ready`=1, else hold.
  - 6 EXEC: to RTYPE_WB.
  - 7 RTYPE_WB: to FETCH.
  - 8 BRANCH: to FETCH.
  - 9 JUMP: to FETCH.
  - 10 ADDI_EX: to ADDI_WB.
  - 11 ADDI_WB: to FETCH.
  - 12 TRAP: absorbing; left only by `rst`.
  - Codes 13–15 go to TRAP on the next edge.
- Outputs are decoded from state. Any output not listed for a state is 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOP=00, PCSource=00. IRWrite and PCWrite both equal `mem_ready`, so PC and IR update exactly once per fetch.
  - DECODE: ALUSrcA=0, ALUSrcB=11, AluOP=00 (branch target precompute).
  - MEMADR, ADDI_EX: ALUSrcA=1, ALUSrcB=10, AluOP=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, AluOP=10.
  - RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, AluOP=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
  - TRAP: ilegal=1.
- `fin_instr`=1 in MEMWB, RTYPE_WB, BRANCH, JUMP and ADDI_WB. In MEMWR it is high only when `mem_ready`=1.
- `opcode` is sampled only in DECODE and MEMADR.

## Timing
- Reset: while `rst`=1, the state is forced to FETCH and every output is forced to 0, including `estado` (0) and the `mem_ready`-gated FETCH outputs. The first active cycle is FETCH, on the first rising edge after `rst` deasserts.
- `rst` asserted mid-instruction, including during a wait state: all outputs drop to 0 immediately, and no partial write may be issued after deassertion.
- Latency with zero wait states (FETCH to FETCH):
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds exactly one cycle. All controls stay constant while holding.
- `mem_ready` is ignored in every state except FETCH, MEMRD and MEMWR.
- State register updates on the rising edge of `clk`. Output changes are glitch-tolerant: combinational decode from registered state, plus `mem_ready` in FETCH and MEMWR only.

## Test plan
- Reset, then R-type (opcode 000000) with `mem_ready`=1: `estado` goes 0,1,6,7,0. AluOP=10 in EXEC; RegWrite=1 and RegDst=1 in state 7. `fin_instr` pulses once.
- lw (100011) with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEMRD: 10 cycles total. IRWrite/PCWrite pulse exactly once. MemtoReg=1 and RegWrite=1 in state 4.
- sw (101011) then beq (000100) back-to-back: sw takes 4 cycles with MemWrite=1 and IorD=1 in state 5. beq takes 3 cycles with AluOP=01, PCWriteCond=1 and PCSource=01 in state 8.
- j (000010) then addi (001000): j has PCWrite=1 and PCSource=10 in state 9. addi runs through states 10 then 11, with ALUSrcB=10, AluOP=00 and RegWrite=1.
- Illegal opcode 111111: the FSM reaches TRAP (12) and `ilegal`=1 holds for 20 cycles. Pulsing `rst` returns it to FETCH with all outputs 0 during reset.
- Assert `rst` in MEMWR while `mem_ready`=0: MemWrite drops to 0 within the same cycle. After release, `estado`=0 and no MemWrite occurs until a new sw reaches state 5.
